idma_job_dispatcher: RTL and testbench



---
 rtl/redmule_tile_pkg.sv | 22 ++
 rtl/idma_job_fifo.sv | 61 ++++++
 rtl/idma_job_dispatcher.sv | 230 +++++++++++++++++++++++
 tb/tb_idma_job_dispatcher.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/redmule_tile_pkg.sv
// rtl/redmule_tile_pkg.sv - shared job/channel types and width defaults for the tile DMA job dispatcher
package redmule_tile_pkg;

    localparam int unsigned IDMA_ADDR_W = 32;
    localparam int unsigned IDMA_LEN_W  = 32;
    localparam int unsigned IDMA_ID_W   = 8;

    typedef enum logic [1:0] {
        IDMA_CH_IDLE  = 2'd0,
        IDMA_CH_ISSUE = 2'd1,
        IDMA_CH_WAIT  = 2'd2
    } idma_ch_state_e;

    typedef struct packed {
        logic [IDMA_ADDR_W-1:0] src;
        logic [IDMA_ADDR_W-1:0] dst;
        logic [IDMA_LEN_W-1:0]  len;
        logic                   dir;
        logic [IDMA_ID_W-1:0]   id;
    } idma_job_t;

endpackage

// File: rtl/idma_job_fifo.sv
// rtl/idma_job_fifo.sv - synchronous job FIFO with flush, full/empty and usage outputs
module idma_job_fifo
    import redmule_tile_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter type         job_t = idma_job_t
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       flush_i,
    input  logic                       push_i,
    input  job_t                       data_i,
    input  logic                       pop_i,
    output job_t                       data_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH+1)-1:0] usage_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH+1);

    job_t             mem_q [DEPTH];
    logic [PTR_W-1:0] wptr_q;
    logic [PTR_W-1:0] rptr_q;
    logic [CNT_W-1:0] cnt_q;
    logic             do_push;
    logic             do_pop;

    // Flush wins over both push and pop in the same cycle.
    assign do_push = push_i && !full_o && !flush_i;
    assign do_pop  = pop_i && !empty_o && !flush_i;

    assign full_o  = (cnt_q == CNT_W'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign usage_o = cnt_q;
    assign data_o  = mem_q[rptr_q];

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (do_push) begin
                wptr_q <= wptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rptr_q <= rptr_q + PTR_W'(1);
            end
            cnt_q <= cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/idma_job_dispatcher.sv
// rtl/idma_job_dispatcher.sv - in-order iDMA job queue feeding the AXI2OBI and OBI2AXI channels
// Optional busy-cycle counters when IDMA_JOB_DISPATCH_PERF_EN is defined.
module idma_job_dispatcher
    import redmule_tile_pkg::*;
#(
    parameter int unsigned QUEUE_DEPTH = 4,
    parameter int unsigned ADDR_W      = IDMA_ADDR_W,
    parameter int unsigned LEN_W       = IDMA_LEN_W,
    parameter int unsigned ID_W        = IDMA_ID_W
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic                             clear_i,
    input  logic                             job_valid_i,
    output logic                             job_ready_o,
    input  logic                             job_dir_i,
    input  logic [ADDR_W-1:0]                job_src_i,
    input  logic [ADDR_W-1:0]                job_dst_i,
    input  logic [LEN_W-1:0]                 job_len_i,
    output logic [ID_W-1:0]                  job_id_o,
    output logic                             a2o_valid_o,
    input  logic                             a2o_ready_i,
    output logic [ADDR_W-1:0]                a2o_src_o,
    output logic [ADDR_W-1:0]                a2o_dst_o,
    output logic [LEN_W-1:0]                 a2o_len_o,
    input  logic                             a2o_done_i,
    input  logic                             a2o_error_i,
    output logic                             a2o_cpl_o,
    output logic [ID_W-1:0]                  a2o_cpl_id_o,
    output logic                             a2o_cpl_err_o,
    output logic                             o2a_valid_o,
    input  logic                             o2a_ready_i,
    output logic [ADDR_W-1:0]                o2a_src_o,
    output logic [ADDR_W-1:0]                o2a_dst_o,
    output logic [LEN_W-1:0]                 o2a_len_o,
    input  logic                             o2a_done_i,
    input  logic                             o2a_error_i,
    output logic                             o2a_cpl_o,
    output logic [ID_W-1:0]                  o2a_cpl_id_o,
    output logic                             o2a_cpl_err_o,
`ifdef IDMA_JOB_DISPATCH_PERF_EN
    output logic [31:0]                      a2o_busy_cnt_o,
    output logic [31:0]                      o2a_busy_cnt_o,
`endif
    output logic [$clog2(QUEUE_DEPTH+1)-1:0] pending_o,
    output logic                             idle_o
);

    localparam logic [1:0] ST_IDLE  = IDMA_CH_IDLE;
    localparam logic [1:0] ST_ISSUE = IDMA_CH_ISSUE;
    localparam logic [1:0] ST_WAIT  = IDMA_CH_WAIT;

    typedef struct packed {
        logic [ADDR_W-1:0] src;
        logic [ADDR_W-1:0] dst;
        logic [LEN_W-1:0]  len;
        logic              dir;
        logic [ID_W-1:0]   id;
    } job_t;

    job_t            push_job;
    job_t            head;
    logic            fifo_full;
    logic            fifo_empty;
    logic            accept;
    logic [ID_W-1:0] id_q;

    logic [1:0]             ch_pop;
    logic [1:0]             ch_idle;
    logic [1:0]             ch_valid;
    logic [1:0]             ch_cpl;
    logic [1:0]             ch_cpl_err;
    logic [1:0][ID_W-1:0]   ch_cpl_id;
    logic [1:0][ADDR_W-1:0] ch_src;
    logic [1:0][ADDR_W-1:0] ch_dst;
    logic [1:0][LEN_W-1:0]  ch_len;
    logic [1:0]             ch_ready;
    logic [1:0]             ch_done;
    logic [1:0]             ch_error;
`ifdef IDMA_JOB_DISPATCH_PERF_EN
    logic [1:0][31:0]       ch_busy;
`endif

    assign ch_ready = {o2a_ready_i, a2o_ready_i};
    assign ch_done  = {o2a_done_i,  a2o_done_i};
    assign ch_error = {o2a_error_i, a2o_error_i};

    assign job_ready_o = !fifo_full;
    assign job_id_o    = id_q;
    // A push coinciding with clear is dropped and does not consume an ID.
    assign accept      = job_valid_i && !fifo_full && !clear_i;

    assign push_job.src = job_src_i;
    assign push_job.dst = job_dst_i;
    assign push_job.len = job_len_i;
    assign push_job.dir = job_dir_i;
    assign push_job.id  = id_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            id_q <= '0;
        end else if (accept) begin
            id_q <= id_q + ID_W'(1);
        end
    end

    idma_job_fifo #(
        .DEPTH (QUEUE_DEPTH),
        .job_t (job_t)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (clear_i),
        .push_i  (accept),
        .data_i  (push_job),
        .pop_i   (|ch_pop),
        .data_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .usage_o (pending_o)
    );

    for (genvar c = 0; c < 2; c++) begin : g_ch
        logic [1:0]        state_q;
        logic [ADDR_W-1:0] src_q;
        logic [ADDR_W-1:0] dst_q;
        logic [LEN_W-1:0]  len_q;
        logic [ID_W-1:0]   id_q;
        logic              cpl_q;
        logic              cpl_err_q;
        logic [ID_W-1:0]   cpl_id_q;

        // Only the channel matching the head direction may pop, so pops never collide.
        assign ch_pop[c] = (state_q == ST_IDLE) && !fifo_empty && (head.dir == 1'(c)) && !clear_i;

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                state_q   <= ST_IDLE;
                src_q     <= '0;
                dst_q     <= '0;
                len_q     <= '0;
                id_q      <= '0;
                cpl_q     <= 1'b0;
                cpl_err_q <= 1'b0;
                cpl_id_q  <= '0;
            end else begin
                cpl_q <= 1'b0;
                case (state_q)
                    ST_IDLE: begin
                        if (ch_pop[c]) begin
                            if (head.len != '0) begin
                                state_q <= ST_ISSUE;
                                src_q   <= head.src;
                                dst_q   <= head.dst;
                                len_q   <= head.len;
                                id_q    <= head.id;
                            end else begin
                                // Zero-length jobs complete locally without touching the channel.
                                cpl_q     <= 1'b1;
                                cpl_id_q  <= head.id;
                                cpl_err_q <= 1'b0;
                            end
                        end
                    end
                    ST_ISSUE: begin
                        if (ch_ready[c]) begin
                            state_q <= ST_WAIT;
                        end
                    end
                    ST_WAIT: begin
                        if (ch_done[c]) begin
                            state_q   <= ST_IDLE;
                            cpl_q     <= 1'b1;
                            cpl_id_q  <= id_q;
                            cpl_err_q <= ch_error[c];
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end

        assign ch_idle[c]    = (state_q == ST_IDLE);
        assign ch_valid[c]   = (state_q == ST_ISSUE);
        assign ch_src[c]     = src_q;
        assign ch_dst[c]     = dst_q;
        assign ch_len[c]     = len_q;
        assign ch_cpl[c]     = cpl_q;
        assign ch_cpl_id[c]  = cpl_id_q;
        assign ch_cpl_err[c] = cpl_err_q;

`ifdef IDMA_JOB_DISPATCH_PERF_EN
        logic [31:0] busy_q;

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                busy_q <= '0;
            end else if ((state_q != ST_IDLE) && (busy_q != 32'hFFFF_FFFF)) begin
                busy_q <= busy_q + 32'd1;
            end
        end

        assign ch_busy[c] = busy_q;
`endif
    end

    assign idle_o = fifo_empty && (&ch_idle);

    assign a2o_valid_o   = ch_valid[0];
    assign a2o_src_o     = ch_src[0];
    assign a2o_dst_o     = ch_dst[0];
    assign a2o_len_o     = ch_len[0];
    assign a2o_cpl_o     = ch_cpl[0];
    assign a2o_cpl_id_o  = ch_cpl_id[0];
    assign a2o_cpl_err_o = ch_cpl_err[0];

    assign o2a_valid_o   = ch_valid[1];
    assign o2a_src_o     = ch_src[1];
    assign o2a_dst_o     = ch_dst[1];
    assign o2a_len_o     = ch_len[1];
    assign o2a_cpl_o     = ch_cpl[1];
    assign o2a_cpl_id_o  = ch_cpl_id[1];
    assign o2a_cpl_err_o = ch_cpl_err[1];

`ifdef IDMA_JOB_DISPATCH_PERF_EN
    assign a2o_busy_cnt_o = ch_busy[0];
    assign o2a_busy_cnt_o = ch_busy[1];
`endif

endmodule

// File: tb/tb_idma_job_dispatcher.sv
// tb/tb_idma_job_dispatcher.sv - directed bench with a queue-level reference model for idma_job_dispatcher
module tb_idma_job_dispatcher;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clear = 1'b0;
    logic        job_valid = 1'b0;
    logic        job_dir = 1'b0;
    logic [31:0] job_src = '0;
    logic [31:0] job_dst = '0;
    logic [31:0] job_len = '0;
    logic        a2o_ready = 1'b0, o2a_ready = 1'b0;
    logic        a2o_done = 1'b0,  o2a_done = 1'b0;
    logic        a2o_error = 1'b0, o2a_error = 1'b0;

    logic        job_ready_o;
    logic [7:0]  job_id_o;
    logic        a2o_valid_o, o2a_valid_o;
    logic [31:0] a2o_src_o, a2o_dst_o, a2o_len_o;
    logic [31:0] o2a_src_o, o2a_dst_o, o2a_len_o;
    logic        a2o_cpl_o, o2a_cpl_o;
    logic [7:0]  a2o_cpl_id_o, o2a_cpl_id_o;
    logic        a2o_cpl_err_o, o2a_cpl_err_o;
    logic [2:0]  pending_o;
    logic        idle_o;
`ifdef IDMA_JOB_DISPATCH_PERF_EN
    logic [31:0] a2o_busy_cnt_o, o2a_busy_cnt_o;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    idma_job_dispatcher #(
        .QUEUE_DEPTH (DEPTH),
        .ADDR_W      (32),
        .LEN_W       (32),
        .ID_W        (8)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .clear_i       (clear),
        .job_valid_i   (job_valid),
        .job_ready_o   (job_ready_o),
        .job_dir_i     (job_dir),
        .job_src_i     (job_src),
        .job_dst_i     (job_dst),
        .job_len_i     (job_len),
        .job_id_o      (job_id_o),
        .a2o_valid_o   (a2o_valid_o),
        .a2o_ready_i   (a2o_ready),
        .a2o_src_o     (a2o_src_o),
        .a2o_dst_o     (a2o_dst_o),
        .a2o_len_o     (a2o_len_o),
        .a2o_done_i    (a2o_done),
        .a2o_error_i   (a2o_error),
        .a2o_cpl_o     (a2o_cpl_o),
        .a2o_cpl_id_o  (a2o_cpl_id_o),
        .a2o_cpl_err_o (a2o_cpl_err_o),
        .o2a_valid_o   (o2a_valid_o),
        .o2a_ready_i   (o2a_ready),
        .o2a_src_o     (o2a_src_o),
        .o2a_dst_o     (o2a_dst_o),
        .o2a_len_o     (o2a_len_o),
        .o2a_done_i    (o2a_done),
        .o2a_error_i   (o2a_error),
        .o2a_cpl_o     (o2a_cpl_o),
        .o2a_cpl_id_o  (o2a_cpl_id_o),
        .o2a_cpl_err_o (o2a_cpl_err_o),
`ifdef IDMA_JOB_DISPATCH_PERF_EN
        .a2o_busy_cnt_o(a2o_busy_cnt_o),
        .o2a_busy_cnt_o(o2a_busy_cnt_o),
`endif
        .pending_o     (pending_o),
        .idle_o        (idle_o)
    );

    // Per-channel views (index 0 = AXI2OBI, 1 = OBI2AXI)
    logic [1:0]  in_rdy, in_done, in_err, d_valid, d_cpl, d_cpl_err;
    logic [31:0] d_src [2];
    logic [31:0] d_dst [2];
    logic [31:0] d_len [2];
    logic [7:0]  d_cpl_id [2];
    assign in_rdy    = {o2a_ready, a2o_ready};
    assign in_done   = {o2a_done, a2o_done};
    assign in_err    = {o2a_error, a2o_error};
    assign d_valid   = {o2a_valid_o, a2o_valid_o};
    assign d_cpl     = {o2a_cpl_o, a2o_cpl_o};
    assign d_cpl_err = {o2a_cpl_err_o, a2o_cpl_err_o};
    assign d_src[0] = a2o_src_o;  assign d_src[1] = o2a_src_o;
    assign d_dst[0] = a2o_dst_o;  assign d_dst[1] = o2a_dst_o;
    assign d_len[0] = a2o_len_o;  assign d_len[1] = o2a_len_o;
    assign d_cpl_id[0] = a2o_cpl_id_o;  assign d_cpl_id[1] = o2a_cpl_id_o;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: job queue, one in-flight job per channel, pending completions.
    typedef struct {
        logic [31:0] src;
        logic [31:0] dst;
        logic [31:0] len;
        logic        dir;
        logic [7:0]  id;
    } mjob_t;

    mjob_t      mq[$];
    mjob_t      m_job [2];
    bit         m_has [2];
    bit         m_taken [2];
    bit         m_cpl [2];
    logic [7:0] m_cpl_id [2];
    bit         m_cpl_err [2];
    int         m_id;
    string      cn [2] = '{"a2o", "o2a"};

    initial begin
        bit    can_push;
        int    pd;
        bit    n_cpl [2];
        mjob_t h;
        forever begin
            @(negedge clk);
            if (rst) begin
                mq.delete();
                m_id = 0;
                for (int c = 0; c < 2; c++) begin
                    m_has[c] = 0; m_taken[c] = 0; m_cpl[c] = 0;
                end
            end else begin
                chk("job_ready", job_ready_o, mq.size() < DEPTH);
                chk("job_id", job_id_o, m_id);
                chk("pending", pending_o, mq.size());
                chk("idle", idle_o, (mq.size() == 0) && !m_has[0] && !m_has[1]);
                for (int c = 0; c < 2; c++) begin
                    chk($sformatf("%s_valid", cn[c]), d_valid[c], m_has[c] && !m_taken[c]);
                    if (m_has[c] && !m_taken[c]) begin
                        chk($sformatf("%s_src", cn[c]), d_src[c], m_job[c].src);
                        chk($sformatf("%s_dst", cn[c]), d_dst[c], m_job[c].dst);
                        chk($sformatf("%s_len", cn[c]), d_len[c], m_job[c].len);
                    end
                    chk($sformatf("%s_cpl", cn[c]), d_cpl[c], m_cpl[c]);
                    if (m_cpl[c]) begin
                        chk($sformatf("%s_cpl_id", cn[c]), d_cpl_id[c], m_cpl_id[c]);
                        chk($sformatf("%s_cpl_err", cn[c]), d_cpl_err[c], m_cpl_err[c]);
                    end
                end

                // Advance the model to the next clock edge using the current inputs.
                can_push = mq.size() < DEPTH;
                pd = -1;
                if (!clear && mq.size() > 0 && !m_has[mq[0].dir]) pd = int'(mq[0].dir);
                for (int c = 0; c < 2; c++) begin
                    n_cpl[c] = 0;
                    if (m_has[c]) begin
                        if (m_taken[c] && in_done[c]) begin
                            n_cpl[c] = 1;
                            m_cpl_id[c] = m_job[c].id;
                            m_cpl_err[c] = in_err[c];
                            m_has[c] = 0;
                        end else if (!m_taken[c] && in_rdy[c]) begin
                            m_taken[c] = 1;
                        end
                    end
                end
                if (pd >= 0) begin
                    h = mq.pop_front();
                    if (h.len == 0) begin
                        n_cpl[pd] = 1;
                        m_cpl_id[pd] = h.id;
                        m_cpl_err[pd] = 0;
                    end else begin
                        m_has[pd] = 1;
                        m_taken[pd] = 0;
                        m_job[pd] = h;
                    end
                end
                if (clear) begin
                    mq.delete();
                end else if (job_valid && can_push) begin
                    mq.push_back('{src: job_src, dst: job_dst, len: job_len, dir: job_dir, id: 8'(m_id)});
                    m_id = (m_id + 1) % 256;
                end
                for (int c = 0; c < 2; c++) m_cpl[c] = n_cpl[c];
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic dir, input logic [31:0] src, input logic [31:0] dst, input logic [31:0] len);
        job_valid = 1'b1; job_dir = dir; job_src = src; job_dst = dst; job_len = len;
        tick();
        job_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        a2o_ready = 1'b1; o2a_ready = 1'b1; a2o_done = 1'b1; o2a_done = 1'b1;
        while (!idle_o && n < 200) begin
            tick();
            n++;
        end
        chk("drain_idle", idle_o, 1'b1);
        a2o_ready = 1'b0; o2a_ready = 1'b0; a2o_done = 1'b0; o2a_done = 1'b0;
        tick();
    endtask

    initial begin
        // Reset values
        tick();
        chk("rst_job_ready", job_ready_o, 1'b1);
        chk("rst_idle", idle_o, 1'b1);
        chk("rst_pending", pending_o, 0);
        chk("rst_job_id", job_id_o, 0);
        chk("rst_valids", {a2o_valid_o, o2a_valid_o}, 2'b00);
        chk("rst_cpls", {a2o_cpl_o, o2a_cpl_o}, 2'b00);
        chk("rst_a2o_src", a2o_src_o, 0);
        chk("rst_o2a_len", o2a_len_o, 0);
        chk("rst_a2o_cpl_id", a2o_cpl_id_o, 0);
        tick();
        rst = 1'b0;
        tick();

        // Single a2o job, channel ready immediately, done 10 cycles later
        a2o_ready = 1'b1;
        push(1'b0, 32'h1000_0000, 32'h0000_0100, 32'd64);
        chk("t1_pending", pending_o, 1);
        tick();
        chk("t1_valid_hi", a2o_valid_o, 1'b1);
        chk("t1_src", a2o_src_o, 32'h1000_0000);
        chk("t1_len", a2o_len_o, 32'd64);
        tick();
        chk("t1_valid_lo", a2o_valid_o, 1'b0);
        a2o_ready = 1'b0;
        repeat (9) tick();
        a2o_done = 1'b1;
        tick();
        a2o_done = 1'b0;
        chk("t1_cpl", a2o_cpl_o, 1'b1);
        chk("t1_cpl_id", a2o_cpl_id_o, 0);
        chk("t1_cpl_err", a2o_cpl_err_o, 1'b0);
        tick();
        chk("t1_cpl_once", a2o_cpl_o, 1'b0);

        // Fill the queue behind a stalled a2o channel
        push(1'b0, 32'h2000_0000, 32'h40, 32'd32);
        tick();
        job_valid = 1'b1; job_dir = 1'b0; job_src = 32'h3000_0000; job_dst = 32'h80; job_len = 32'd16;
        repeat (5) tick();
        chk("t2_pending_full", pending_o, 4);
        chk("t2_ready_lo", job_ready_o, 1'b0);
        chk("t2_job_id", job_id_o, 6);
        a2o_ready = 1'b1;
        tick();
        a2o_ready = 1'b0; a2o_done = 1'b1;
        tick();
        a2o_done = 1'b0;
        chk("t2_cpl_id", a2o_cpl_id_o, 1);
        tick();
        chk("t2_pending_pop", pending_o, 3);
        chk("t2_ready_hi", job_ready_o, 1'b1);
        tick();
        job_valid = 1'b0;
        chk("t2_pending_refill", pending_o, 4);
        drain();

        // Head-of-line blocking
        a2o_ready = 1'b1;
        push(1'b0, 32'h4000_0000, 32'h200, 32'd8);
        tick(); tick();
        push(1'b0, 32'h4000_1000, 32'h300, 32'd8);
        push(1'b0, 32'h4000_2000, 32'h400, 32'd8);
        push(1'b1, 32'h0000_0500, 32'h5000_0000, 32'd8);
        repeat (3) tick();
        chk("t3_pending", pending_o, 3);
        chk("t3_o2a_blocked", o2a_valid_o, 1'b0);
        a2o_done = 1'b1;
        tick();
        a2o_done = 1'b0;
        chk("t3_cpl_id", a2o_cpl_id_o, 7);
        drain();

        // Zero-length o2a job
        push(1'b1, 32'h5000, 32'h6000, 32'd0);
        chk("t4_pending", pending_o, 1);
        tick();
        chk("t4_cpl", o2a_cpl_o, 1'b1);
        chk("t4_cpl_id", o2a_cpl_id_o, 11);
        chk("t4_cpl_err", o2a_cpl_err_o, 1'b0);
        chk("t4_no_valid", o2a_valid_o, 1'b0);
        tick();
        chk("t4_cpl_once", o2a_cpl_o, 1'b0);

        // Simultaneous completions, o2a with error
        a2o_ready = 1'b1; o2a_ready = 1'b1;
        push(1'b0, 32'h7000_0000, 32'h700, 32'd4);
        push(1'b1, 32'h0000_0800, 32'h8000_0000, 32'd4);
        repeat (3) tick();
        a2o_done = 1'b1; o2a_done = 1'b1; o2a_error = 1'b1;
        tick();
        a2o_done = 1'b0; o2a_done = 1'b0; o2a_error = 1'b0;
        a2o_ready = 1'b0; o2a_ready = 1'b0;
        chk("t5_cpls", {a2o_cpl_o, o2a_cpl_o}, 2'b11);
        chk("t5_a2o_err", a2o_cpl_err_o, 1'b0);
        chk("t5_o2a_err", o2a_cpl_err_o, 1'b1);
        chk("t5_a2o_id", a2o_cpl_id_o, 12);
        chk("t5_o2a_id", o2a_cpl_id_o, 13);
        tick();

        // Clear while a2o is waiting
        a2o_ready = 1'b1;
        push(1'b0, 32'h9000_0000, 32'h900, 32'd128);
        tick(); tick();
        push(1'b0, 32'h9000_1000, 32'hA00, 32'd16);
        push(1'b1, 32'h0000_0B00, 32'hB000_0000, 32'd16);
        push(1'b0, 32'h9000_2000, 32'hC00, 32'd16);
        chk("t6_pending_pre", pending_o, 3);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("t6_pending_clr", pending_o, 0);
        repeat (3) tick();
        a2o_done = 1'b1;
        tick();
        a2o_done = 1'b0; a2o_ready = 1'b0;
        chk("t6_cpl", a2o_cpl_o, 1'b1);
        chk("t6_cpl_id", a2o_cpl_id_o, 14);
        tick();
        chk("t6_idle", idle_o, 1'b1);
        chk("t6_job_id", job_id_o, 18);
        repeat (3) tick();

        // ID wrap via back-to-back zero-length jobs
        job_valid = 1'b1; job_dir = 1'b0; job_src = 32'h1; job_dst = 32'h2; job_len = 32'd0;
        repeat (238) tick();
        job_valid = 1'b0;
        chk("wrap_job_id", job_id_o, 0);
        repeat (3) tick();
        chk("wrap_idle", idle_o, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
